rgb_luma_stage: RTL and testbench

//   Downstream consumer of the RGB pixel pass-through stage: takes its r/g/b component stream and

---
 rtl/rgb_pkg.sv | 17 +
 rtl/rgb_luma_mac.sv | 17 +
 rtl/rgb_luma_stage.sv | 108 ++++++++++
 tb/tb_rgb_luma_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types and default coefficients for the RGB luma pipeline.
package rgb_pkg;

   localparam int unsigned COMP_W  = 8;
   localparam int unsigned SUM_W   = 18;

   localparam int unsigned LUMA_CR = 77;
   localparam int unsigned LUMA_CG = 150;
   localparam int unsigned LUMA_CB = 29;

   typedef struct packed {
      logic [COMP_W-1:0] r;
      logic [COMP_W-1:0] g;
      logic [COMP_W-1:0] b;
   } rgb_t;

endpackage

// File: rtl/rgb_luma_mac.sv
// Combinational weighted sum of one RGB pixel with fixed 8-bit coefficients.
module rgb_luma_mac
   import rgb_pkg::*;
#(
   parameter int unsigned CR = LUMA_CR,
   parameter int unsigned CG = LUMA_CG,
   parameter int unsigned CB = LUMA_CB
) (
   input  rgb_t             pix,
   output logic [SUM_W-1:0] sum
);

   always_comb begin
      sum = SUM_W'(CR * pix.r + CG * pix.g + CB * pix.b);
   end

endmodule

// File: rtl/rgb_luma_stage.sv
// Two-stage valid/ready RGB-to-luma converter with end-of-line tagging.
// Optional RGB_LUMA_BYPASS_EN adds a `bypass` input that passes green through.
module rgb_luma_stage
   import rgb_pkg::*;
#(
   parameter int unsigned CR       = LUMA_CR,
   parameter int unsigned CG       = LUMA_CG,
   parameter int unsigned CB       = LUMA_CB,
   parameter int unsigned LINE_LEN = 640
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [COMP_W-1:0] in_r,
   input  logic [COMP_W-1:0] in_g,
   input  logic [COMP_W-1:0] in_b,
`ifdef RGB_LUMA_BYPASS_EN
   input  logic              bypass,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   output logic [COMP_W-1:0] out_y,
   output logic              out_eol,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int unsigned       COL_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LINE_LEN - 1);

   rgb_t             pix;
   logic [SUM_W-1:0] mac_sum;
   logic [SUM_W-1:0] s1_next;
   logic [SUM_W-1:0] s1_sum;
   logic [SUM_W-1:0] rounded;
   logic [7:0]       y_sat;
   logic             s1_valid;
   logic             s1_eol;
   logic             s1_en;
   logic             s2_en;
   logic             in_fire;
   logic             col_last;
   logic [COL_W-1:0] col;

   always_comb begin
      pix = '{r: in_r, g: in_g, b: in_b};
   end

   rgb_luma_mac #(
      .CR (CR),
      .CG (CG),
      .CB (CB)
   ) u_mac (
      .pix (pix),
      .sum (mac_sum)
   );

   always_comb begin
      s2_en    = !out_valid || out_ready;
      s1_en    = !s1_valid || s2_en;
      in_ready = s1_en;
      in_fire  = in_valid && s1_en;
      col_last = (col == COL_LAST);
   end

   // Bypassed pixels store g<<8 as the sum: the rounding stage then yields g exactly.
   always_comb begin
      s1_next = mac_sum;
`ifdef RGB_LUMA_BYPASS_EN
      if (bypass) begin
         s1_next = SUM_W'({in_g, 8'h00});
      end
`endif
   end

   always_comb begin
      rounded = (s1_sum + SUM_W'(128)) >> 8;
      y_sat   = (|rounded[SUM_W-1:8]) ? '1 : rounded[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_sum    <= '0;
         s1_eol    <= 1'b0;
         out_valid <= 1'b0;
         out_y     <= '0;
         out_eol   <= 1'b0;
         col       <= '0;
      end else begin
         if (s1_en) begin
            s1_valid <= in_valid;
         end
         if (in_fire) begin
            s1_sum <= s1_next;
            s1_eol <= col_last;
            col    <= col_last ? '0 : col + COL_W'(1);
         end
         if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_y   <= y_sat;
               out_eol <= s1_eol;
            end
         end
      end
   end

endmodule

// File: tb/tb_rgb_luma_stage.sv
// Randomised self-checking bench for rgb_luma_stage against a queue-based luma model.
module tb_rgb_luma_stage;
   import rgb_pkg::*;

   localparam int unsigned LL = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_r, in_g, in_b;
   logic       in_valid, in_ready;
   logic [7:0] out_y;
   logic       out_eol, out_valid, out_ready;
   logic       bypass_drv;
   logic       sat_in_ready, sat_eol, sat_valid;
   logic [7:0] sat_y;

   typedef struct {
      logic [7:0] y;
      logic       eol;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_now;
   int   col_m;
   int   vectors;
   int   miscompares;
   logic out_fire;
   logic exp_hit;

   always #5 clk = ~clk;

   rgb_luma_stage #(
      .LINE_LEN (LL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_r      (in_r),
      .in_g      (in_g),
      .in_b      (in_b),
`ifdef RGB_LUMA_BYPASS_EN
      .bypass    (bypass_drv),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_y     (out_y),
      .out_eol   (out_eol),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   rgb_luma_stage #(
      .CR       (255),
      .CG       (255),
      .CB       (255),
      .LINE_LEN (LL)
   ) u_sat (
      .clk       (clk),
      .rst       (rst),
      .in_r      (in_r),
      .in_g      (in_g),
      .in_b      (in_b),
`ifdef RGB_LUMA_BYPASS_EN
      .bypass    (1'b0),
`endif
      .in_valid  (in_valid),
      .in_ready  (sat_in_ready),
      .out_y     (sat_y),
      .out_eol   (sat_eol),
      .out_valid (sat_valid),
      .out_ready (out_ready)
   );

   function automatic logic [7:0] luma(input int unsigned cr, input int unsigned cg,
                                       input int unsigned cb, input logic [7:0] r,
                                       input logic [7:0] g, input logic [7:0] b);
      int unsigned s;
      s = (cr * r + cg * g + cb * b + 128) / 256;
      return (s > 255) ? 8'd255 : 8'(s);
   endfunction

   // One clock of stimulus; updates the model and pops the expectation for this cycle's output beat.
   task automatic advance(input logic v, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input logic ordy);
      exp_t e;
      @(negedge clk);
      in_valid   = v;
      in_r       = r;
      in_g       = g;
      in_b       = b;
      out_ready  = ordy;
      #1;
      out_fire = out_valid && out_ready;
      exp_hit  = 1'b0;
      if (out_fire && exp_q.size() > 0) begin
         exp_now = exp_q.pop_front();
         exp_hit = 1'b1;
      end
      if (v && in_ready) begin
         e.y   = bypass_drv ? g : luma(LUMA_CR, LUMA_CG, LUMA_CB, r, g, b);
         e.eol = (col_m == LL - 1);
         col_m = (col_m == LL - 1) ? 0 : col_m + 1;
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      exp_q.delete();
      col_m = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_y !== 8'd0 || out_eol !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: valid=%b y=%0d eol=%b, expected 0/0/0", out_valid, out_y, out_eol);
      end
      rst = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_single();
      advance(1'b1, 8'd255, 8'd255, 8'd255, 1'b1);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL single_accept: in_ready=%b expected 1", in_ready);
      end
      advance(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_early: out_valid=%b expected 0", out_valid);
      end
      advance(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
      vectors++;
      if (out_valid !== 1'b1 || out_y !== 8'd255 || !exp_hit || out_eol !== exp_now.eol) begin
         miscompares++;
         $display("FAIL single_beat: valid=%b y=%0d eol=%b, expected 1/255/%b", out_valid, out_y, out_eol, exp_now.eol);
      end
      advance(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_dup: out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_stream();
      logic [7:0] pr[4] = '{8'd255, 8'd0, 8'd0, 8'd100};
      logic [7:0] pg[4] = '{8'd0, 8'd255, 8'd0, 8'd50};
      logic [7:0] pb[4] = '{8'd0, 8'd0, 8'd255, 8'd200};
      logic [7:0] ey[4] = '{8'd77, 8'd149, 8'd29, 8'd82};
      int n = 0;
      int last = 0;
      for (int c = 0; c < 10; c++) begin
         if (c < 4) advance(1'b1, pr[c], pg[c], pb[c], 1'b1);
         else       advance(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
         if (out_fire) begin
            vectors++;
            if (n >= 4 || out_y !== ey[n] || !exp_hit || out_y !== exp_now.y || (n > 0 && c != last + 1)) begin
               miscompares++;
               $display("FAIL stream_%0d: y=%0d cycle=%0d, expected y=%0d cycle=%0d", n, out_y, c,
                        (n < 4) ? ey[n] : 8'd0, last + 1);
            end
            last = c;
            n++;
         end
      end
      vectors++;
      if (n != 4) begin
         miscompares++;
         $display("FAIL stream_count: got %0d beats, expected 4", n);
      end
   endtask

   task automatic test_eol();
      int k = 0;
      pulse_rst();
      for (int c = 0; c < 20; c++) begin
         if (c < 12) advance(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
         else        advance(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
         if (out_fire) begin
            vectors++;
            if (!exp_hit || out_y !== exp_now.y || out_eol !== exp_now.eol || out_eol !== (k % 4 == 3)) begin
               miscompares++;
               $display("FAIL eol_%0d: y=%0d eol=%b, expected y=%0d eol=%b", k, out_y, out_eol, exp_now.y, (k % 4 == 3));
            end
            k++;
         end
      end
      vectors++;
      if (k != 12) begin
         miscompares++;
         $display("FAIL eol_count: got %0d beats, expected 12", k);
      end
   endtask

   task automatic test_stall();
      logic [7:0] held;
      pulse_rst();
      advance(1'b1, 8'd10, 8'd20, 8'd30, 1'b0);
      advance(1'b1, 8'd40, 8'd50, 8'd60, 1'b0);
      held = out_y;
      for (int c = 0; c < 5; c++) begin
         advance(1'b1, 8'd70, 8'd80, 8'd90, 1'b0);
         if (c == 0) held = out_y;
         vectors++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== held || out_y !== exp_q[0].y) begin
            miscompares++;
            $display("FAIL stall_%0d: in_ready=%b valid=%b y=%0d, expected 0/1/%0d", c, in_ready, out_valid, out_y, exp_q[0].y);
         end
      end
      for (int c = 0; c < 14; c++) begin
         if (c < 5) advance(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
         else       advance(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
         if (out_fire) begin
            vectors++;
            if (!exp_hit || out_y !== exp_now.y || out_eol !== exp_now.eol) begin
               miscompares++;
               $display("FAIL stall_release: y=%0d eol=%b, expected y=%0d eol=%b queued=%b", out_y, out_eol, exp_now.y, exp_now.eol, exp_hit);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL stall_loss: %0d pixels never emitted, expected 0", exp_q.size());
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 420; c++) begin
         if (c < 400) advance($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 9) < 6);
         else         advance(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
         if (out_fire) begin
            vectors++;
            if (!exp_hit || out_y !== exp_now.y || out_eol !== exp_now.eol) begin
               miscompares++;
               $display("FAIL random_%0d: y=%0d eol=%b, expected y=%0d eol=%b queued=%b", c, out_y, out_eol, exp_now.y, exp_now.eol, exp_hit);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL random_loss: %0d pixels never emitted, expected 0", exp_q.size());
      end
   endtask

   task automatic test_midreset();
      int k = 0;
      advance(1'b1, 8'd1, 8'd2, 8'd3, 1'b0);
      advance(1'b1, 8'd4, 8'd5, 8'd6, 1'b0);
      pulse_rst();
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_valid: out_valid=%b expected 0", out_valid);
      end
      for (int c = 0; c < 12; c++) begin
         if (c >= 3 && c < 7) advance(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
         else                 advance(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
         vectors++;
         if (out_fire) begin
            if (!exp_hit || out_y !== exp_now.y || out_eol !== (k == 3)) begin
               miscompares++;
               $display("FAIL midreset_%0d: y=%0d eol=%b, expected y=%0d eol=%b queued=%b", k, out_y, out_eol, exp_now.y, (k == 3), exp_hit);
            end
            k++;
         end else if (out_valid !== 1'b0 && c < 5) begin
            miscompares++;
            $display("FAIL midreset_ghost: out_valid=%b expected 0", out_valid);
         end
      end
      vectors++;
      if (k != 4) begin
         miscompares++;
         $display("FAIL midreset_count: got %0d beats, expected 4", k);
      end
   endtask

   task automatic test_saturation();
      pulse_rst();
      advance(1'b1, 8'd255, 8'd255, 8'd255, 1'b1);
      advance(1'b1, 8'd1, 8'd2, 8'd3, 1'b1);
      advance(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
      vectors++;
      if (sat_valid !== 1'b1 || sat_y !== luma(255, 255, 255, 8'd255, 8'd255, 8'd255)) begin
         miscompares++;
         $display("FAIL sat_white: valid=%b y=%0d, expected 1/255", sat_valid, sat_y);
      end
      advance(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
      vectors++;
      if (sat_valid !== 1'b1 || sat_y !== luma(255, 255, 255, 8'd1, 8'd2, 8'd3)) begin
         miscompares++;
         $display("FAIL sat_small: valid=%b y=%0d, expected 1/%0d", sat_valid, sat_y, luma(255, 255, 255, 8'd1, 8'd2, 8'd3));
      end
      repeat (3) advance(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
      exp_q.delete();
   endtask

`ifdef RGB_LUMA_BYPASS_EN
   task automatic test_bypass();
      pulse_rst();
      bypass_drv = 1'b1;
      advance(1'b1, 8'd10, 8'd200, 8'd30, 1'b1);
      bypass_drv = 1'b0;
      advance(1'b1, 8'd10, 8'd200, 8'd30, 1'b1);
      for (int c = 0; c < 6; c++) begin
         advance(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
         if (out_fire) begin
            vectors++;
            if (!exp_hit || out_y !== exp_now.y || out_eol !== exp_now.eol) begin
               miscompares++;
               $display("FAIL bypass: y=%0d eol=%b, expected y=%0d eol=%b", out_y, out_eol, exp_now.y, exp_now.eol);
            end
         end
      end
   endtask
`endif

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_r        = 8'd0;
      in_g        = 8'd0;
      in_b        = 8'd0;
      out_ready   = 1'b1;
      bypass_drv  = 1'b0;
      col_m       = 0;
      vectors     = 0;
      miscompares = 0;
      out_fire    = 1'b0;
      exp_hit     = 1'b0;
      test_reset();
      test_single();
      test_stream();
      test_eol();
      test_stall();
      test_random();
      test_midreset();
      test_saturation();
`ifdef RGB_LUMA_BYPASS_EN
      test_bypass();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
